// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and opcode classification for the iterative ALU.
package alu_pkg;

    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_SUB   = 6'd1;
    localparam logic [5:0] OP_AND   = 6'd2;
    localparam logic [5:0] OP_OR    = 6'd3;
    localparam logic [5:0] OP_SLT   = 6'd4;
    localparam logic [5:0] OP_MUL   = 6'd5;
    localparam logic [5:0] OP_XOR   = 6'd6;
    localparam logic [5:0] OP_SLTU  = 6'd7;
    localparam logic [5:0] OP_SLL   = 6'd8;
    localparam logic [5:0] OP_SRL   = 6'd9;
    localparam logic [5:0] OP_SRA   = 6'd10;
    localparam logic [5:0] OP_MULH  = 6'd11;
    localparam logic [5:0] OP_MULHU = 6'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_mul_op(input logic [5:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHU);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier on operand magnitudes, UNROLL multiplier bits per cycle.
// The start cycle performs the first step; done_o flags the cycle whose step is final (product_o valid then).
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [XLEN-1:0]     a_i,
    input  logic [XLEN-1:0]     b_i,
    input  logic                signed_i,
    output logic                done_o,
    output logic [2*XLEN-1:0]   product_o
);

    localparam int STEPS = XLEN / UNROLL;
    localparam int CW    = $clog2(STEPS + 1);

    logic              busy_q, busy_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic              neg_q, neg_d;

    logic [XLEN-1:0]   a_mag, b_mag;
    logic [2*XLEN-1:0] src_acc, src_mcand;
    logic [XLEN-1:0]   src_mplier;
    logic              last;

    assign a_mag = (signed_i && a_i[XLEN-1]) ? -a_i : a_i;
    assign b_mag = (signed_i && b_i[XLEN-1]) ? -b_i : b_i;

    // On start the step works straight from the fresh operands so no cycle is spent loading.
    assign src_acc    = start_i ? '0 : acc_q;
    assign src_mcand  = start_i ? {{XLEN{1'b0}}, a_mag} : mcand_q;
    assign src_mplier = start_i ? b_mag : mplier_q;
    assign neg_d      = start_i ? (signed_i & (a_i[XLEN-1] ^ b_i[XLEN-1])) : neg_q;

    assign last = start_i ? (STEPS == 1) : (busy_q && (cnt_q == CW'(STEPS - 1)));

    always_comb begin
        acc_d = src_acc;
        for (int i = 0; i < UNROLL; i++) begin
            if (src_mplier[i]) begin
                acc_d = acc_d + (src_mcand << i);
            end
        end
        mcand_d  = src_mcand << UNROLL;
        mplier_d = src_mplier >> UNROLL;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        if (start_i || busy_q) begin
            busy_d = !last;
            cnt_d  = last ? '0 : (start_i ? CW'(1) : cnt_q + CW'(1));
        end
    end

    assign done_o    = last;
    assign product_o = neg_d ? -acc_d : acc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            if (start_i || busy_q) begin
                acc_q    <= acc_d;
                mcand_q  <= mcand_d;
                mplier_q <= mplier_d;
                neg_q    <= neg_d;
            end
        end
    end

endmodule

// File: rtl/alu_pipe_iter.sv
// Valid/ready ALU: single-cycle ops registered at accept, multiplies run iteratively (XLEN/UNROLL cycles).
// Result held until out_ready; a new request may be accepted on the same edge the result is consumed.
module alu_pipe_iter
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] ID_EX_A,
    input  logic [XLEN-1:0] ID_EX_B,
    input  logic [5:0]      opcode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALU_result,
    output logic            ovf,
    output logic            err
);

    localparam int SHW = $clog2(XLEN);

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            ovf_q, ovf_d;
    logic            err_q, err_d;
    logic [5:0]      op_q, op_d;

    logic              accept;
    logic              mul_start;
    logic              mul_done;
    logic [2*XLEN-1:0] mul_prod;

    logic [XLEN-1:0] alu_res;
    logic            alu_ovf;
    logic            alu_err;
    logic [XLEN-1:0] sum, diff;
    logic [SHW-1:0]  shamt;

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);

    assign sum   = ID_EX_A + ID_EX_B;
    assign diff  = ID_EX_A - ID_EX_B;
    assign shamt = ID_EX_B[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_err = 1'b0;
        unique case (opcode)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (ID_EX_A[XLEN-1] == ID_EX_B[XLEN-1]) && (sum[XLEN-1] != ID_EX_A[XLEN-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (ID_EX_A[XLEN-1] != ID_EX_B[XLEN-1]) && (diff[XLEN-1] != ID_EX_A[XLEN-1]);
            end
            OP_AND:  alu_res = ID_EX_A & ID_EX_B;
            OP_OR:   alu_res = ID_EX_A | ID_EX_B;
            OP_XOR:  alu_res = ID_EX_A ^ ID_EX_B;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(ID_EX_A) < $signed(ID_EX_B))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (ID_EX_A < ID_EX_B)};
            OP_SLL:  alu_res = ID_EX_A << shamt;
            OP_SRL:  alu_res = ID_EX_A >> shamt;
            OP_SRA:  alu_res = $signed(ID_EX_A) >>> shamt;
            OP_MUL, OP_MULH, OP_MULHU: alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    function automatic logic [XLEN-1:0] mul_pick(input logic [5:0] op, input logic [2*XLEN-1:0] prod);
        return (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    endfunction

    alu_mul_iter #(
        .XLEN   (XLEN),
        .UNROLL (UNROLL)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .a_i       (ID_EX_A),
        .b_i       (ID_EX_B),
        .signed_i  (opcode == OP_MULH),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        op_d      = op_q;
        mul_start = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if ((state_q == ST_DONE) && out_ready) begin
                    state_d = ST_IDLE;
                end
                if (accept) begin
                    op_d = opcode;
                    if (is_mul_op(opcode)) begin
                        mul_start = 1'b1;
                        // Only reachable when a single step covers the whole multiplier.
                        if (mul_done) begin
                            state_d  = ST_DONE;
                            result_d = mul_pick(opcode, mul_prod);
                            ovf_d    = 1'b0;
                            err_d    = 1'b0;
                        end else begin
                            state_d = ST_BUSY;
                        end
                    end else begin
                        state_d  = ST_DONE;
                        result_d = alu_res;
                        ovf_d    = alu_ovf;
                        err_d    = alu_err;
                    end
                end
            end
            ST_BUSY: begin
                if (mul_done) begin
                    state_d  = ST_DONE;
                    result_d = mul_pick(op_q, mul_prod);
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            op_q     <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            op_q     <= op_d;
        end
    end

    assign ALU_result = result_q;
    assign ovf        = ovf_q;
    assign err        = err_q;

endmodule

// File: tb/tb_alu_pipe_iter.sv
// Directed plus random scoreboard bench for alu_pipe_iter at UNROLL=1 (dut0) and UNROLL=4 (dut1).
module tb_alu_pipe_iter;

    localparam logic [5:0] T_ADD = 6'd0, T_SUB = 6'd1, T_AND = 6'd2, T_OR = 6'd3, T_SLT = 6'd4;
    localparam logic [5:0] T_MUL = 6'd5, T_XOR = 6'd6, T_SLTU = 6'd7, T_SLL = 6'd8, T_SRL = 6'd9;
    localparam logic [5:0] T_SRA = 6'd10, T_MULH = 6'd11, T_MULHU = 6'd12;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  in_valid, in_ready, out_valid, out_ready, ovf, err;
    logic [31:0] opa [2];
    logic [31:0] opb [2];
    logic [31:0] res [2];
    logic [5:0]  opc [2];

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   hs0    = 0;
    int   n_res0 = 0;

    logic [5:0] op_tab [14] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6,
                                6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd63};

    always #5 clk = ~clk;

    alu_pipe_iter #(.XLEN(32), .UNROLL(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .ID_EX_A(opa[0]), .ID_EX_B(opb[0]), .opcode(opc[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .ALU_result(res[0]), .ovf(ovf[0]), .err(err[0])
    );

    alu_pipe_iter #(.XLEN(32), .UNROLL(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .ID_EX_A(opa[1]), .ID_EX_B(opb[1]), .opcode(opc[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .ALU_result(res[1]), .ovf(ovf[1]), .err(err[1])
    );

    always @(posedge clk) begin
        if (!rst && out_valid[0] && out_ready[0]) hs0++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input int d);
        exp_t            e;
        longint          sa, sbv;
        longint unsigned ua, ub;
        logic [63:0]     p;
        ua  = 64'(a);
        ub  = 64'(b);
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        e   = '{res: 32'd0, ovf: 1'b0, err: 1'b0, lat: 1};
        case (op)
            T_ADD: begin
                e.res = a + b;
                e.ovf = (a[31] == b[31]) && (e.res[31] != a[31]);
            end
            T_SUB: begin
                e.res = a - b;
                e.ovf = (a[31] != b[31]) && (e.res[31] != a[31]);
            end
            T_AND:  e.res = a & b;
            T_OR:   e.res = a | b;
            T_XOR:  e.res = a ^ b;
            T_SLT:  e.res = 32'($signed(a) < $signed(b));
            T_SLTU: e.res = 32'(a < b);
            T_SLL:  e.res = a << b[4:0];
            T_SRL:  e.res = a >> b[4:0];
            T_SRA:  e.res = $signed(a) >>> b[4:0];
            T_MUL: begin
                p = ua * ub;
                e.res = p[31:0];
                e.lat = (d == 0) ? 32 : 8;
            end
            T_MULH: begin
                p = 64'(sa * sbv);
                e.res = p[63:32];
                e.lat = (d == 0) ? 32 : 8;
            end
            T_MULHU: begin
                p = ua * ub;
                e.res = p[63:32];
                e.lat = (d == 0) ? 32 : 8;
            end
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    // Presents a request at a falling edge and returns at the falling edge after the accepting edge.
    task automatic issue(input int d, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        opc[d] = op;
        opa[d] = a;
        opb[d] = b;
        in_valid[d] = 1'b1;
        while (!in_ready[d] && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk1("accept_rdy", in_ready[d], 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        opa[d] = $urandom();
        opb[d] = $urandom();
        opc[d] = 6'($urandom());
    endtask

    task automatic expect_out(input int d, input string tag);
        int   lat;
        exp_t e;
        lat = 1;
        while (!out_valid[d] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk1({tag, "_vld"}, out_valid[d], 1'b1);
        chk1({tag, "_sb"}, sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
            chk({tag, "_res"}, res[d], e.res);
            chk1({tag, "_ovf"}, ovf[d], e.ovf);
            chk1({tag, "_err"}, err[d], e.err);
        end
        if (d == 0) n_res0++;
    endtask

    task automatic run(input int d, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic o, input logic e, input int lat, input string tag);
        sb.push_back('{res: r, ovf: o, err: e, lat: lat});
        issue(d, op, a, b);
        expect_out(d, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0]  op;
        logic [31:0] a, b;
        logic        seen;

        rst = 1'b1;
        in_valid = 2'b00;
        out_ready = 2'b11;
        for (int k = 0; k < 2; k++) begin
            opa[k] = '0;
            opb[k] = '0;
            opc[k] = '0;
        end
        repeat (3) @(negedge clk);
        chk1("rst_vld", out_valid[0], 1'b0);
        chk("rst_res", res[0], 32'd0);
        chk1("rst_ovf", ovf[0], 1'b0);
        chk1("rst_err", err[0], 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk1("rst_in_rdy0", in_ready[0], 1'b1);
        chk1("rst_in_rdy1", in_ready[1], 1'b1);

        run(0, T_ADD, 32'd10, 32'd5, 32'd15, 1'b0, 1'b0, 1, "add_basic");
        run(0, T_ADD, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b1, 1'b0, 1, "add_ovf");
        run(0, T_SUB, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b1, 1'b0, 1, "sub_ovf");
        run(0, T_SLT, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1, "slt");
        run(0, T_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1, "sltu");
        run(0, T_SRA, 32'h80000000, 32'd36, 32'hF8000000, 1'b0, 1'b0, 1, "sra36");
        run(0, T_MUL, 32'd65536, 32'd65536, 32'd0, 1'b0, 1'b0, 32, "mul_u1");
        run(0, T_MULHU, 32'd65536, 32'd65536, 32'd1, 1'b0, 1'b0, 32, "mulhu_u1");
        run(0, T_MULH, -32'sd6, 32'd7, 32'hFFFFFFFF, 1'b0, 1'b0, 32, "mulh_u1");
        run(0, T_MUL, -32'sd6, 32'd7, 32'hFFFFFFD6, 1'b0, 1'b0, 32, "mul_neg_u1");
        run(0, 6'd63, 32'hAAAAAAAA, 32'd3, 32'd0, 1'b0, 1'b1, 1, "bad_op");

        run(1, T_MUL, 32'd65536, 32'd65536, 32'd0, 1'b0, 1'b0, 8, "mul_u4");
        run(1, T_MULHU, 32'd65536, 32'd65536, 32'd1, 1'b0, 1'b0, 8, "mulhu_u4");
        run(1, T_MULH, -32'sd6, 32'd7, 32'hFFFFFFFF, 1'b0, 1'b0, 8, "mulh_u4");
        run(1, T_MUL, -32'sd6, 32'd7, 32'hFFFFFFD6, 1'b0, 1'b0, 8, "mul_neg_u4");
        run(1, T_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b0, 8, "mulh_min_u4");

        // Backpressure: result must hold while the consumer stalls, then hand off to a same-edge issue.
        out_ready[0] = 1'b0;
        run(0, T_SUB, 32'd5, 32'd10, 32'hFFFFFFFB, 1'b0, 1'b0, 1, "sub_bp");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1("bp_vld", out_valid[0], 1'b1);
            chk("bp_hold", res[0], 32'hFFFFFFFB);
            chk1("bp_in_rdy", in_ready[0], 1'b0);
        end
        opc[0] = T_ADD;
        opa[0] = 32'd3;
        opb[0] = 32'd4;
        in_valid[0] = 1'b1;
        out_ready[0] = 1'b1;
        #1;
        chk1("b2b_in_rdy", in_ready[0], 1'b1);
        sb.push_back('{res: 32'd7, ovf: 1'b0, err: 1'b0, lat: 1});
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        expect_out(0, "b2b_add");

        // Reset ten cycles into a multiply must discard it.
        issue(0, T_MUL, 32'd123, 32'd456);
        repeat (9) @(negedge clk);
        chk1("abort_pre_vld", out_valid[0], 1'b0);
        rst = 1'b1;
        #1;
        chk1("abort_rst_vld", out_valid[0], 1'b0);
        chk("abort_rst_res", res[0], 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid[0]) seen = 1'b1;
        end
        chk1("abort_no_result", seen, 1'b0);
        chk1("abort_in_rdy", in_ready[0], 1'b1);
        run(0, T_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1, "add_after_abort");

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 12; i++) begin
                op = op_tab[$urandom_range(13, 0)];
                a  = $urandom();
                b  = $urandom();
                if (i == 0) a = 32'h80000000;
                sb.push_back(model(op, a, b, d));
                issue(d, op, a, b);
                expect_out(d, "rnd");
            end
        end

        repeat (3) @(negedge clk);
        chk("hs_count", 32'(hs0), 32'(n_res0));
        chk1("final_idle_vld", out_valid[0], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe_iter.md
ALU_PIPE_ITER -- requirements
Module: alu_pipe_iter

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (even, >=8).
REQ-002 SHALL have parameter UNROLL, default 1, multiplier bits retired per cycle (1, 2, 4 or 8; must divide XLEN).
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have port in_valid  in  1  request present.
REQ-006 SHALL have port in_ready  out  1  request accepted when in_valid && in_ready at a rising edge.
REQ-007 SHALL have port ID_EX_A  in  XLEN  operand A.
REQ-008 SHALL have port ID_EX_B  in  XLEN  operand B.
REQ-009 SHALL have port opcode  in  6  operation select.
REQ-010 SHALL have port out_valid  out  1  result valid.
REQ-011 SHALL have port out_ready  in  1  consumer accepts result when out_valid && out_ready at a rising edge.
REQ-012 SHALL have port ALU_result  out  XLEN  result.
REQ-013 SHALL have port ovf  out  1  signed overflow (ADD/SUB only, else 0).
REQ-014 SHALL have port err  out  1  unsupported opcode flag.

Function
REQ-015 SHALL decode opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT (signed), 5 MUL (low XLEN), 6 XOR, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 MULH (signed x signed, high XLEN), 12 MULHU (unsigned, high XLEN).
REQ-016 SHALL use only the low log2(XLEN) bits of B as shift amount.
REQ-017 SHALL implement FSM states IDLE, BUSY, DONE; IDLE->DONE on accepted non-multiply op; IDLE->BUSY on accepted MUL/MULH/MULHU; BUSY->DONE after the final step; DONE->IDLE on out_ready without new accept; DONE->DONE/BUSY on out_ready with simultaneous accept.
REQ-018 SHALL assert in_ready in IDLE, and in DONE only while out_ready is high (back-to-back issue); low in BUSY.
REQ-019 SHALL register operands and opcode at accept; inputs ignored otherwise.
REQ-020 Single-cycle ops accepted at edge N SHALL present out_valid and result from edge N+1.
REQ-021 Multiply ops accepted at edge N SHALL present out_valid from edge N+XLEN/UNROLL (32 cycles at defaults), via iterative shift-add on operand magnitudes with final two's-complement negation of the 2*XLEN product for MULH when signs differ.
REQ-022 SHALL hold ALU_result, ovf, err stable while out_valid && !out_ready.
REQ-023 SHALL set ovf for ADD when operand signs equal and result sign differs; for SUB when operand signs differ and result sign differs from A.
REQ-024 Unsupported opcode SHALL complete as single-cycle op with ALU_result=0, err=1.
REQ-025 SLT/SLTU SHALL return 1 or 0 zero-extended to XLEN.

Reset
REQ-026 rst high SHALL immediately force state IDLE, out_valid=0, ALU_result=0, ovf=0, err=0, iteration counter=0; in_ready reads 1 one cycle after release.
REQ-027 rst during BUSY SHALL abort the multiply with no result produced.

Structure
REQ-028 Opcode constants and state encodings SHALL reside in shared package alu_pkg.
REQ-029 Iterative multiplier SHALL be sub-module alu_mul_iter (start, operands, signed mode, done, 2*XLEN product), parametrised by XLEN and UNROLL.

Verification
REQ-030 ADD 10+5, out_ready=1 -> ALU_result=15, out_valid one cycle after accept, ovf=0; ADD 0x7FFFFFFF+1 -> 0x80000000, ovf=1.
REQ-031 SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0; SRA 0x80000000 by 36 -> 0xF8000000.
REQ-032 MUL 65536*65536 -> 0, latency 32; MULHU same -> 1; MULH -6*7 -> 0xFFFFFFFF; MUL -6*7 -> 0xFFFFFFD6; repeat with UNROLL=4 -> latency 8.
REQ-033 out_ready held low 3 cycles after SUB 5-10 -> result 0xFFFFFFFB held, in_ready low, single handshake on release; back-to-back ADD accepted same edge.
REQ-034 rst asserted 10 cycles into MUL -> out_valid stays 0, next ADD 1+1 returns 2 normally.
REQ-035 opcode 63 with A=0xAAAAAAAA -> ALU_result=0, err=1, ovf=0.
